// File: rtl/compute_energy_multichannel.sv
// Per-channel windowed sum of squared samples, one saturating result per 2**WINDOW_LOG2 samples, 1-cycle latency.
// Input stalls while an untaken result is held; COMPUTE_ENERGY_MEAN_EN selects mean power (sum >> WINDOW_LOG2).
module compute_energy_multichannel #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SIGNED       = 1,
  parameter int ENERGY_WIDTH = 32,
  parameter int WINDOW_LOG2  = 4,
  parameter int CHANNELS     = 2,
  parameter int CH_WIDTH     = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic [CH_WIDTH-1:0]     sample_channel,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [ENERGY_WIDTH-1:0] energy_data,
  output logic [CH_WIDTH-1:0]     energy_channel,
  output logic                    energy_saturated,
  output logic                    energy_valid,
  input  logic                    energy_ready
);

  localparam int SQW = 2 * SAMPLE_WIDTH;
  localparam int WW  = ((ENERGY_WIDTH > SQW) ? ENERGY_WIDTH : SQW) + 1;
  localparam int CW  = WINDOW_LOG2 + 1;
  localparam int IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] WIN_LEN = CW'(64'd1 << WINDOW_LOG2);
  localparam logic [WW-1:0] MAX_W   = WW'({ENERGY_WIDTH{1'b1}});

  logic [ENERGY_WIDTH-1:0] acc [CHANNELS];
  logic [CW-1:0]           cnt [CHANNELS];
  logic                    sat [CHANNELS];

  logic                    accept;
  logic                    ch_ok;
  logic [IW-1:0]           idx;
  logic [SQW-1:0]          ext;
  logic [SQW-1:0]          sq;
  logic [WW-1:0]           sq_w;
  logic [WW-1:0]           sq_c;
  logic [WW-1:0]           sum_w;
  logic                    clip;
  logic [ENERGY_WIDTH-1:0] acc_next;
  logic [CW-1:0]           cnt_next;
  logic                    sat_next;
  logic                    win_end;
  logic [ENERGY_WIDTH-1:0] result;

  assign sample_ready = !energy_valid || energy_ready;

  always_comb begin
    accept = sample_valid && sample_ready;
    ch_ok  = 32'(sample_channel) < CHANNELS;
    idx    = IW'(sample_channel);
    if (SIGNED != 0) ext = {{SAMPLE_WIDTH{sample_data[SAMPLE_WIDTH-1]}}, sample_data};
    else             ext = {{SAMPLE_WIDTH{1'b0}}, sample_data};
    // The true square always fits in SQW bits, so the truncated product is exact.
    sq       = ext * ext;
    sq_w     = WW'(sq);
    sq_c     = (sq_w > MAX_W) ? MAX_W : sq_w;
    sum_w    = WW'(acc[idx]) + sq_c;
    clip     = (sq_w > MAX_W) || (sum_w > MAX_W);
    acc_next = clip ? MAX_W[ENERGY_WIDTH-1:0] : sum_w[ENERGY_WIDTH-1:0];
    cnt_next = cnt[idx] + 1'b1;
    sat_next = sat[idx] | clip;
    win_end  = (cnt_next == WIN_LEN);
`ifdef COMPUTE_ENERGY_MEAN_EN
    result   = acc_next >> WINDOW_LOG2;
`else
    result   = acc_next;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        sat[i] <= 1'b0;
      end
      energy_data      <= '0;
      energy_channel   <= '0;
      energy_saturated <= 1'b0;
      energy_valid     <= 1'b0;
    end else begin
      if (accept && ch_ok) begin
        if (win_end) begin
          acc[idx] <= '0;
          cnt[idx] <= '0;
          sat[idx] <= 1'b0;
        end else begin
          acc[idx] <= acc_next;
          cnt[idx] <= cnt_next;
          sat[idx] <= sat_next;
        end
      end
      // A closing window reloads the output even during a handshake, so there is no bubble.
      if (accept && ch_ok && win_end) begin
        energy_data      <= result;
        energy_channel   <= sample_channel;
        energy_saturated <= sat_next;
        energy_valid     <= 1'b1;
      end else if (energy_ready) begin
        energy_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_compute_energy_multichannel.sv
`timescale 1ns/1ps
module tb_compute_energy_multichannel;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // u0: signed, 20-bit energy, window 4, two channels
  logic [15:0] s0_data;
  logic        s0_ch, s0_valid, s0_ready;
  logic [19:0] e0_data;
  logic        e0_ch, e0_sat, e0_valid, e0_ready;

  // u1: unsigned, 32-bit energy, window 1, one channel
  logic [15:0] s1_data;
  logic        s1_ch, s1_valid, s1_ready;
  logic [31:0] e1_data;
  logic        e1_ch, e1_sat, e1_valid, e1_ready;

  compute_energy_multichannel #(.SAMPLE_WIDTH(16), .SIGNED(1), .ENERGY_WIDTH(20),
    .WINDOW_LOG2(2), .CHANNELS(2), .CH_WIDTH(1)) u0 (
    .clock(clock), .reset(reset),
    .sample_data(s0_data), .sample_channel(s0_ch), .sample_valid(s0_valid), .sample_ready(s0_ready),
    .energy_data(e0_data), .energy_channel(e0_ch), .energy_saturated(e0_sat),
    .energy_valid(e0_valid), .energy_ready(e0_ready));

  compute_energy_multichannel #(.SAMPLE_WIDTH(16), .SIGNED(0), .ENERGY_WIDTH(32),
    .WINDOW_LOG2(0), .CHANNELS(1), .CH_WIDTH(1)) u1 (
    .clock(clock), .reset(reset),
    .sample_data(s1_data), .sample_channel(s1_ch), .sample_valid(s1_valid), .sample_ready(s1_ready),
    .energy_data(e1_data), .energy_channel(e1_ch), .energy_saturated(e1_sat),
    .energy_valid(e1_valid), .energy_ready(e1_ready));

`ifdef COMPUTE_ENERGY_MEAN_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif
  localparam longint MAX0 = 64'hFFFFF;

  typedef struct packed {
    logic        ch;
    logic [19:0] data;
    logic        sat;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  longint m_acc[2];
  int     m_cnt[2];
  bit     m_sat[2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
      m_sat[i] = 0;
    end
  endtask

  task automatic model(input bit ch, input logic [15:0] d);
    longint s, sqr;
    bit c;
    exp_t e;
    s = longint'($signed(d));
    sqr = s * s;
    c = 0;
    if (sqr > MAX0) begin sqr = MAX0; c = 1; end
    m_acc[ch] += sqr;
    if (m_acc[ch] > MAX0) begin m_acc[ch] = MAX0; c = 1; end
    m_sat[ch] |= c;
    m_cnt[ch]++;
    if (m_cnt[ch] == 4) begin
      e.ch = ch;
      e.data = 20'(m_acc[ch] >> SH);
      e.sat = m_sat[ch];
      q.push_back(e);
      m_acc[ch] = 0;
      m_cnt[ch] = 0;
      m_sat[ch] = 0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send0(input bit ch, input logic [15:0] d);
    int t;
    bit ok;
    s0_ch = ch;
    s0_data = d;
    s0_valid = 1'b1;
    t = 0;
    ok = 0;
    while (!ok && t < 200) begin
      @(negedge clock);
      if (s0_ready) ok = 1;
      else t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send0_timeout: got ready 0 expected 1");
      @(posedge clock);
    end else begin
      @(posedge clock);
      model(ch, d);
    end
    #1 s0_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && e0_valid && e0_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL e0_unexpected: got output %0h expected none", e0_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("e0_data", e0_data, e.data);
        check("e0_channel", e0_ch, e.ch);
        check("e0_saturated", e0_sat, e.sat);
      end
    end
  end

  typedef struct {
    logic        ch;
    logic [15:0] d;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    vec_t v[7];
    logic [19:0] held;

    v[0] = '{1'b0, 16'h0000, 1'b1, 32'h0000_0000};
    v[1] = '{1'b0, 16'h0001, 1'b1, 32'h0000_0001};
    v[2] = '{1'b0, 16'hFFFF, 1'b1, 32'hFFFE_0001};
    v[3] = '{1'b0, 16'h8000, 1'b1, 32'h4000_0000};
    v[4] = '{1'b1, 16'h0005, 1'b0, 32'h0000_0000};
    v[5] = '{1'b0, 16'h00FF, 1'b1, 32'h0000_FE01};
    v[6] = '{1'b0, 16'h0003, 1'b1, 32'h0000_0009};

    reset = 1'b1;
    s0_data = '0; s0_ch = 0; s0_valid = 0; e0_ready = 1;
    s1_data = '0; s1_ch = 0; s1_valid = 0; e1_ready = 1;
    model_clear();
    cyc(3);
    reset = 1'b0;
    @(negedge clock);
    check("rst_e0_valid", e0_valid, 0);
    check("rst_e0_data", e0_data, 0);
    check("rst_e0_sat", e0_sat, 0);
    check("rst_s0_ready", s0_ready, 1);
    check("rst_e1_valid", e1_valid, 0);
    check("rst_e1_data", e1_data, 0);
    @(posedge clock); #1;

    for (int i = 1; i <= 4; i++) send0(0, 16'(i));
    send0(1, -16'sd3); send0(1, 16'd3); send0(1, -16'sd3); send0(1, 16'd3);
    send0(0, 2); send0(1, 5); send0(0, 3); send0(1, 1);
    send0(0, 1); send0(1, 0); send0(0, 1); send0(1, 0);
    repeat (4) send0(0, 16'h7FFF);
    repeat (4) send0(0, 16'h0001);
    repeat (4) send0(1, 16'h8000);
    cyc(3);

    // Backpressure: ch1 three samples in, ch0 window closes with output stalled.
    e0_ready = 1'b0;
    repeat (3) send0(1, 2);
    for (int i = 1; i <= 4; i++) send0(0, 16'(i));
    @(negedge clock);
    check("bp_valid", e0_valid, 1);
    check("bp_ready_low", s0_ready, 0);
    held = e0_data;
    @(posedge clock); #1;
    fork
      send0(1, 3);
      begin
        repeat (5) begin
          @(negedge clock);
          check("bp_sample_ready", s0_ready, 0);
          check("bp_hold_data", e0_data, held);
        end
        @(posedge clock); #1;
        e0_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("b2b_valid", e0_valid, 1);
        check("b2b_channel", e0_ch, 1);
      end
    join
    cyc(3);

    // Reset mid-window discards the partial sum.
    repeat (3) send0(0, 16'd5);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    model_clear();
    q.delete();
    @(negedge clock);
    check("rst2_e0_valid", e0_valid, 0);
    check("rst2_s0_ready", s0_ready, 1);
    @(posedge clock); #1;
    repeat (4) send0(0, 16'd1);

    for (int i = 0; i < 40; i++) begin
      if ((i % 7) == 3) e0_ready = 1'b0;
      else e0_ready = 1'b1;
      send0(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)));
    end
    e0_ready = 1'b1;

    for (int i = 0; i < 7; i++) begin
      s1_ch = v[i].ch;
      s1_data = v[i].d;
      s1_valid = 1'b1;
      @(negedge clock);
      check("u1_ready", s1_ready, 1);
      @(posedge clock); #1;
      s1_valid = 1'b0;
      @(negedge clock);
      check("u1_valid", e1_valid, v[i].exp_valid);
      if (v[i].exp_valid) begin
        check("u1_data", e1_data, v[i].exp_data);
        check("u1_sat", e1_sat, 0);
      end
      @(posedge clock); #1;
    end

    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clock);
    cyc(2);
    check("drain_queue", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
